// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_if
// Description : Handshake/data bundle between the execute stage and the
//               multi-cycle divider.
//                 signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//                 opdata1_i     dividend
//                 opdata2_i     divisor
//                 start_i       request, held until ready_o
//                 annul_i       abort (flush / exception)
//                 result_o      {remainder, quotient}
//                 ready_o       result valid
//               Suffixes are named from the divider's point of view.
//               master = execute stage, slave = divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle DIV/DIVU unit, one radix-2 restoring step per
//               clock. Returns {remainder, quotient} with a ready flag.
//               Ports:
//                 clk  clock, rising edge
//                 rst  synchronous reset, active low
//                 bus  div_unit_if.slave (operands, start/annul, result/ready)
//               Optional build macro DIV_EARLY_OUT_EN: when |dividend| <
//               |divisor| the iterations are skipped (quotient 0, remainder =
//               dividend). Results are identical in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32   // must equal DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]          state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  // {remainder, dividend/quotient}. The remainder always stays below the
  // divisor, so it fits in DATA_W bits; the extra trial bit lives only in
  // the combinational candidate below.
  logic [2*DATA_W-1:0] work_q,    work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q,  result_d;
  logic                ready_q,   ready_d;

  // --------------------------------------------------------------------------
  // Operand conditioning (only consumed in FREE)
  // --------------------------------------------------------------------------
  logic              w_go;
  logic              w_dvd_neg;
  logic              w_dvs_neg;
  logic [DATA_W-1:0] w_dvd_abs;
  logic [DATA_W-1:0] w_dvs_abs;
  logic              w_div_zero;
  logic              w_early;

  assign w_go       = bus.start_i & ~bus.annul_i;
  assign w_dvd_neg  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign w_dvs_neg  = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign w_dvd_abs  = w_dvd_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign w_dvs_abs  = w_dvs_neg ? -bus.opdata2_i : bus.opdata2_i;
  assign w_div_zero = (bus.opdata2_i == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_dvd_abs < w_dvs_abs) & ~w_div_zero;
`else
  assign w_early = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // One restoring step: shift in the next dividend bit, try the subtraction
  // --------------------------------------------------------------------------
  logic [DATA_W:0]     w_cand;
  logic                w_ge;
  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_step;

  assign w_cand = work_q[2*DATA_W-1:DATA_W-1];
  assign w_ge   = (w_cand >= {1'b0, divisor_q});
  // When w_ge holds the difference is below the divisor, so DATA_W bits suffice.
  assign w_diff = w_cand[DATA_W-1:0] - divisor_q;
  assign w_step = w_ge ? {w_diff,              work_q[DATA_W-2:0], 1'b1}
                       : {w_cand[DATA_W-1:0],  work_q[DATA_W-2:0], 1'b0};

  // Sign correction of the finished result
  logic [DATA_W-1:0] w_quo;
  logic [DATA_W-1:0] w_rem;

  assign w_quo = neg_quo_q ? -work_q[DATA_W-1:0]        : work_q[DATA_W-1:0];
  assign w_rem = neg_rem_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (w_go) begin
          // Early-out reuses the one-cycle BYZERO pass so both short paths
          // share the same latency.
          if (w_div_zero || w_early) state_d = S_BYZERO;
          else                       state_d = S_ON;
        end
      end
      S_BYZERO: state_d = w_go ? S_END : S_FREE;
      S_ON: begin
        if (!w_go)                            state_d = S_FREE;
        else if (cnt_q == CNT_W'(ITER - 1))  state_d = S_END;
      end
      S_END:    state_d = w_go ? S_END : S_FREE;
      default:  state_d = S_FREE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = '0;
    ready_d   = 1'b0;
    case (state_q)
      S_FREE: begin
        if (w_go) begin
          cnt_d     = '0;
          divisor_d = w_dvs_abs;
          neg_quo_d = w_dvd_neg ^ w_dvs_neg;
          neg_rem_d = w_dvd_neg;
          if (w_div_zero)   work_d = '0;
          else if (w_early) work_d = {w_dvd_abs, {DATA_W{1'b0}}};
          else              work_d = {{DATA_W{1'b0}}, w_dvd_abs};
        end
      end
      S_ON: begin
        cnt_d  = cnt_q + 1'b1;
        work_d = w_step;
      end
      S_END: begin
        if (w_go) begin
          result_d = {w_rem, w_quo};
          ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit. Inputs change and
//               outputs are sampled 1 ns after the rising edge. Latency is the
//               number of rising edges from the issue edge E0 (counted as 1)
//               up to the first edge after which ready_o is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
  endtask

  // Counts edges until ready_o is seen; bounded so a dead DUT cannot hang.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ready_o && n < 200);
  endtask

  task automatic release_op();
    bus.start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    repeat (3) tick();
    checks++;
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
    checks++;
    if (bus.result_o !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    int n;
    issue(1'b0, 32'd100, 32'd7);
    wait_ready(n);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL udiv_latency: got %0d expected 34", n); end
    checks++;
    if (bus.result_o !== 64'h00000002_0000000E) begin errors++; $display("FAIL udiv_result: got %h expected 000000020000000e", bus.result_o); end
    tick();
    checks++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL udiv_hold: got ready %b result %h expected 1 000000020000000e", bus.ready_o, bus.result_o);
    end
    release_op();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      errors++; $display("FAIL udiv_release: got ready %b result %h expected 0 0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_signed();
    int n;
    issue(1'b1, 32'hFFFFFFF9, 32'h00000002);   // -7 / 2
    wait_ready(n);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL sdiv_latency: got %0d expected 34", n); end
    checks++;
    if (bus.result_o !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL sdiv_neg7_2: got %h expected fffffffffffffffd", bus.result_o); end
    release_op();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_ready(n);
    checks++;
    if (bus.result_o !== 64'h00000000_80000000) begin errors++; $display("FAIL sdiv_min_m1: got %h expected 0000000080000000", bus.result_o); end
    release_op();
    issue(1'b1, 32'd7, 32'hFFFFFFFE);           // 7 / -2
    wait_ready(n);
    checks++;
    if (bus.result_o !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL sdiv_7_neg2: got %h expected 00000001fffffffd", bus.result_o); end
    release_op();
  endtask

  task automatic test_div_zero();
    int n;
    for (int m = 0; m < 2; m++) begin
      issue(m[0], 32'h00001234, 32'h0);
      wait_ready(n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL divzero_latency_mode%0d: got %0d expected 3", m, n); end
      checks++;
      if (bus.result_o !== 64'h0) begin errors++; $display("FAIL divzero_result_mode%0d: got %h expected 0", m, bus.result_o); end
      // annul while in END acts like dropping start
      bus.annul_i = 1'b1;
      tick();
      checks++;
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL divzero_annul_end_mode%0d: got ready %b expected 0", m, bus.ready_o); end
      bus.annul_i = 1'b0;
      release_op();
    end
  endtask

  task automatic test_abort();
    int  n;
    logic seen;
    issue(1'b0, 32'd1000, 32'd3);
    repeat (10) tick();            // edges E0 .. E0+9
    bus.annul_i = 1'b1;
    tick();                        // E0+10
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = bus.ready_o;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | bus.ready_o;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b expected 0", seen); end
    issue(1'b0, 32'd9, 32'd3);
    wait_ready(n);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL abort_next_latency: got %0d expected 34", n); end
    checks++;
    if (bus.result_o !== 64'h00000000_00000003) begin errors++; $display("FAIL abort_next_result: got %h expected 0000000000000003", bus.result_o); end
    release_op();
  endtask

  task automatic test_reset_mid();
    int n;
    issue(1'b0, 32'd50, 32'd5);
    repeat (20) tick();            // edges E0 .. E0+19
    rst = 1'b0;
    tick();                        // E0+20
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      errors++; $display("FAIL rstmid_clear: got ready %b result %h expected 0 0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    rst = 1'b1;
    tick();
    issue(1'b0, 32'd50, 32'd5);
    wait_ready(n);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL rstmid_latency: got %0d expected 34", n); end
    checks++;
    if (bus.result_o !== 64'h00000000_0000000A) begin errors++; $display("FAIL rstmid_result: got %h expected 000000000000000a", bus.result_o); end
    release_op();
  endtask

  task automatic test_early_out();
    int n;
    int exp_short;
`ifdef DIV_EARLY_OUT_EN
    exp_short = 3;
`else
    exp_short = 34;
`endif
    issue(1'b0, 32'd3, 32'd10);
    wait_ready(n);
    checks++;
    if (n !== exp_short) begin errors++; $display("FAIL early_latency: got %0d expected %0d", n, exp_short); end
    checks++;
    if (bus.result_o !== 64'h00000003_00000000) begin errors++; $display("FAIL early_result: got %h expected 0000000300000000", bus.result_o); end
    release_op();
    issue(1'b1, 32'hFFFFFFFD, 32'd10);          // -3 / 10
    wait_ready(n);
    checks++;
    if (bus.result_o !== 64'hFFFFFFFD_00000000) begin errors++; $display("FAIL early_signed_result: got %h expected fffffffd00000000", bus.result_o); end
    release_op();
    issue(1'b0, 32'd100, 32'd7);
    wait_ready(n);
    checks++;
    if (n !== 34) begin errors++; $display("FAIL early_full_latency: got %0d expected 34", n); end
    release_op();
  endtask

  task automatic test_back_to_back();
    int n;
    issue(1'b0, 32'hFFFFFFFF, 32'h10);
    tick();                        // E0
    bus.opdata1_i = 32'd1;         // must be ignored while busy
    bus.opdata2_i = 32'd1;
    bus.signed_div_i = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", n); end
    checks++;
    if (bus.result_o !== 64'h0000000F_0FFFFFFF) begin errors++; $display("FAIL b2b_first: got %h expected 0000000f0fffffff", bus.result_o); end
    release_op();
    issue(1'b1, 32'hFFFFFC18, 32'd7);           // -1000 / 7
    wait_ready(n);
    checks++;
    if (bus.result_o !== 64'hFFFFFFFA_FFFFFF72) begin errors++; $display("FAIL b2b_second: got %h expected fffffffaffffff72", bus.result_o); end
    release_op();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_abort();
    test_reset_mid();
    test_early_out();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit divider for DIV/DIVU, one radix-2 restoring iteration per clock.
- Sits beside the execute stage and consumes its `div_opdata1_o`, `div_opdata2_o`, `div_start_o` and `signed_div_o`.
- Returns `{remainder, quotient}` and a ready flag, which execute writes to HI/LO.
- Execute holds `start_i` high and stalls the pipe until `ready_o`, then drops `start_i`.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W.
- ITER, 32, number of iterations; must equal DATA_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset, sampled on the rising edge of `clk`).
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; held high by execute until `ready_o`.
- annul_i  in  1  abort the current operation (pipeline flush or exception).
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid.

Behaviour:
- Reset (`rst`=0 at an edge):
  - state = FREE, `ready_o`=0, `result_o`=0, iteration counter=0.
  - Applies in any state, including mid-division.
- States: FREE, BYZERO, ON, END.
- FREE:
  - `start_i`=1 and `annul_i`=0 at edge E0: latch the operands and sign mode.
  - If the divisor is 0, go to BYZERO; otherwise go to ON with counter=0.
  - Otherwise stay in FREE with `ready_o`=0 and `result_o`=0.
- Signed mode:
  - Operands with bit31=1 are replaced by their two's complement before iterating.
  - Quotient is negated if the original signs differ.
  - Remainder is negated if the original dividend was negative.
  - All arithmetic is mod 2^32, so 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- Iteration:
  - 65-bit working register {rem[32:0], dvd[31:0]}.
  - Each ON edge: shift left 1, then compute trial = rem[32:1] − divisor.
  - If trial ≥ 0 (no borrow): rem = trial and the shifted-in quotient bit = 1.
  - Otherwise keep rem and the quotient bit = 0.
  - Counter increments each ON edge; the edge with counter==31 (E32) moves to END.
- BYZERO: next edge moves to END with quotient=0 and remainder=0.
- END:
  - Each edge with `start_i`=1: `result_o` = signed-corrected {rem, quo}, `ready_o`=1, stay in END.
  - Edge with `start_i`=0: go to FREE, `ready_o`=0, `result_o`=0.
- Latency (normal): `ready_o` is first high after edge E0+33 (34 cycles of stall including the issue cycle).
- Latency (divide by zero): `ready_o` is first high after edge E0+2.
- Abort: `annul_i`=1, or `start_i`=0, at any edge in ON or BYZERO returns to FREE and clears the outputs; no result is produced.
- `annul_i` in END behaves as `start_i`=0.
- Inputs are sampled only at E0; operand changes while busy are ignored.
- `ready_o` and `result_o` are registered, with no combinational path from the inputs.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- With the macro defined:
  - In FREE at E0, if |dividend| < |divisor| (and the divisor is nonzero), skip ON.
  - Go directly to END with quotient=0 and remainder=original dividend (sign preserved).
  - `ready_o` is then high after edge E0+2.
- Without the macro: always 32 iterations, and latency is fixed as above.
- The result is identical in both builds; only the latency differs.

Test Plan:
- Unsigned divide:
  - Stimulus: `signed_div_i`=0, 100/7, `start_i` held.
  - Required: `ready_o` rises after E0+33 and `result_o`=0x00000002_0000000E.
  - Then drop `start_i`: `ready_o` and `result_o` are 0 after the next edge.
- Signed divide:
  - Stimulus: −7/2 (0xFFFFFFF9 / 0x00000002).
  - Required: `result_o`=0xFFFFFFFF_FFFFFFFD.
  - Stimulus: 0x80000000 / 0xFFFFFFFF.
  - Required: `result_o`=0x00000000_80000000.
- Divide by zero:
  - Stimulus: 0x1234 / 0, signed and unsigned.
  - Required: `ready_o` after E0+2 and `result_o`=0 in both modes.
- Abort:
  - Stimulus: pulse `annul_i` at E0+10.
  - Required: state returns to FREE, `ready_o` never rises, and a new start of 9/3 immediately afterwards gives 0x00000000_00000003.
- Reset mid-operation:
  - Stimulus: `rst`=0 at E0+20.
  - Required: `ready_o`=0 and `result_o`=0 on the next edge; the next operation of 50/5 is correct with full latency.
- DIV_EARLY_OUT_EN build:
  - Stimulus: 3/10.
  - Required: `ready_o` after E0+2 with `result_o`=0x00000003_00000000.
  - Stimulus: 100/7.
  - Required: still 34 cycles.
